text_console: RTL and testbench

Character-stream front end for the text display. It accepts characters through a valid/ready handshake, tracks a cursor, and handles the control codes. It issues single-cycle writes into the frame buffer's write port. Each write uses the cell format {R[7:0], G[7:0], B[7:0], char[7:0]} at address {19'd0, row[5:0], col[6:0]}. The existing display path reads these cells and renders them through the font ROM.

---
 rtl/text_console.sv | 220 ++++++++++++++++++++++
 tb/tb_text_console.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/text_console.sv
// ---------------------------------------------------------------------------
// text_console
//
// Character-stream front end for the text display. Characters arrive over a
// valid/ready handshake; the block keeps a cursor, interprets a small set of
// control codes and issues one frame-buffer cell write per cycle.
//
// Cell format : {R[7:0], G[7:0], B[7:0], char[7:0]}
// Cell address: {19'd0, row[5:0], col[6:0]}
//
// Ports
//   iClk        system clock (same domain as the frame buffer)
//   iRst        synchronous, active-high reset; restarts a full screen clear
//   iValid      producer has a character on iChar/iColor
//   oReady      block accepts a character this cycle (state == IDLE)
//   iChar       character code
//   iColor      {R,G,B} foreground, sampled together with iChar
//   oWriteEn    frame-buffer write strobe (registered)
//   oWAddr      frame-buffer cell address (registered)
//   oWData      frame-buffer cell data (registered)
//   oCursorRow  current cursor row
//   oCursorCol  current cursor column
//   oBusy       high while a screen or line clear is running
//
// Control codes
//   0x08 backspace, 0x0A newline, 0x0C form feed, 0x0D carriage return.
//   Every other code is printable. There is no scrolling: advancing past the
//   last row wraps to row 0, and every row entered is blanked first.
// ---------------------------------------------------------------------------
module text_console #(
  parameter int          COLS        = 80,
  parameter int          ROWS        = 30,
  parameter logic [7:0]  BLANK_CHAR  = 8'h20,
  parameter logic [23:0] BLANK_COLOR = 24'h000000
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic        iValid,
  output logic        oReady,
  input  logic [7:0]  iChar,
  input  logic [23:0] iColor,
  output logic        oWriteEn,
  output logic [31:0] oWAddr,
  output logic [31:0] oWData,
  output logic [5:0]  oCursorRow,
  output logic [6:0]  oCursorCol,
  output logic        oBusy
);

  // Cell counter must at least cover a whole screen; never narrower than 12.
  localparam int CELLS_N = ROWS * COLS;
  localparam int CNT_W   = ($clog2(CELLS_N + 1) > 12) ? $clog2(CELLS_N + 1) : 12;

  localparam logic [5:0]       LAST_ROW   = 6'(ROWS - 1);
  localparam logic [6:0]       LAST_COL   = 7'(COLS - 1);
  localparam logic [CNT_W-1:0] SCREEN_CNT = CNT_W'(CELLS_N);
  localparam logic [CNT_W-1:0] LINE_CNT   = CNT_W'(COLS);
  localparam logic [31:0]      BLANK_WORD = {BLANK_COLOR, BLANK_CHAR};

  localparam logic [7:0] CH_BS = 8'h08;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_FF = 8'h0C;
  localparam logic [7:0] CH_CR = 8'h0D;

  typedef enum logic [1:0] {
    CLEAR_SCREEN = 2'd0,
    IDLE         = 2'd1,
    CLEAR_LINE   = 2'd2
  } state_t;

  state_t            state;
  logic [5:0]        cur_row;
  logic [6:0]        cur_col;
  logic [5:0]        clr_row;
  logic [6:0]        clr_col;
  logic [CNT_W-1:0]  clr_cnt;
  logic [5:0]        nxt_row;

  // Frame-buffer address of a cell.
  function automatic logic [31:0] cell_addr(input logic [5:0] r, input logic [6:0] c);
    return {19'd0, r, c};
  endfunction

  // Row that follows r, wrapping from the last row back to the top.
  function automatic logic [5:0] row_after(input logic [5:0] r);
    return (r == LAST_ROW) ? 6'd0 : r + 6'd1;
  endfunction

  assign nxt_row    = row_after(cur_row);
  assign oReady     = (state == IDLE);
  assign oBusy      = ~oReady;
  assign oCursorRow = cur_row;
  assign oCursorCol = cur_col;

  // Single registered FSM; every frame-buffer output leaves on a flop.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      // Abandon whatever was running; the clear starts from cell 0 next cycle.
      state    <= CLEAR_SCREEN;
      cur_row  <= 6'd0;
      cur_col  <= 7'd0;
      clr_row  <= 6'd0;
      clr_col  <= 7'd0;
      clr_cnt  <= '0;
      oWriteEn <= 1'b0;
      oWAddr   <= 32'd0;
      oWData   <= 32'd0;
    end else begin
      case (state)
        CLEAR_SCREEN: begin
          if (clr_cnt == SCREEN_CNT) begin
            oWriteEn <= 1'b0;
            state    <= IDLE;
          end else begin
            oWriteEn <= 1'b1;
            oWAddr   <= cell_addr(clr_row, clr_col);
            oWData   <= BLANK_WORD;
            clr_cnt  <= clr_cnt + CNT_W'(1);
            // Row-major walk that stops at COLS-1; columns beyond are skipped.
            if (clr_col == LAST_COL) begin
              clr_col <= 7'd0;
              clr_row <= clr_row + 6'd1;
            end else begin
              clr_col <= clr_col + 7'd1;
            end
          end
        end

        CLEAR_LINE: begin
          if (clr_cnt == LINE_CNT) begin
            oWriteEn <= 1'b0;
            state    <= IDLE;
          end else begin
            oWriteEn <= 1'b1;
            oWAddr   <= cell_addr(clr_row, clr_col);
            oWData   <= BLANK_WORD;
            clr_cnt  <= clr_cnt + CNT_W'(1);
            clr_col  <= clr_col + 7'd1;
          end
        end

        IDLE: begin
          oWriteEn <= 1'b0;
          if (iValid) begin
            case (iChar)
              CH_LF: begin
                // The first blank of the new row goes out on the accept edge
                // so the clear occupies exactly the next COLS cycles.
                cur_row  <= nxt_row;
                cur_col  <= 7'd0;
                oWriteEn <= 1'b1;
                oWAddr   <= cell_addr(nxt_row, 7'd0);
                oWData   <= BLANK_WORD;
                clr_row  <= nxt_row;
                clr_col  <= 7'd1;
                clr_cnt  <= CNT_W'(1);
                state    <= CLEAR_LINE;
              end

              CH_CR: begin
                cur_col <= 7'd0;
              end

              CH_BS: begin
                // No reverse wrap: backspace at column 0 is a no-op.
                if (cur_col != 7'd0) begin
                  cur_col  <= cur_col - 7'd1;
                  oWriteEn <= 1'b1;
                  oWAddr   <= cell_addr(cur_row, cur_col - 7'd1);
                  oWData   <= BLANK_WORD;
                end
              end

              CH_FF: begin
                // Same early-first-write trick as newline, for the whole screen.
                cur_row  <= 6'd0;
                cur_col  <= 7'd0;
                oWriteEn <= 1'b1;
                oWAddr   <= cell_addr(6'd0, 7'd0);
                oWData   <= BLANK_WORD;
                clr_row  <= 6'd0;
                clr_col  <= 7'd1;
                clr_cnt  <= CNT_W'(1);
                state    <= CLEAR_SCREEN;
              end

              default: begin
                oWriteEn <= 1'b1;
                oWAddr   <= cell_addr(cur_row, cur_col);
                oWData   <= {iColor, iChar};
                if (cur_col == LAST_COL) begin
                  // The character write owns this edge, so the line clear
                  // starts one cycle later from column 0.
                  cur_col <= 7'd0;
                  cur_row <= nxt_row;
                  clr_row <= nxt_row;
                  clr_col <= 7'd0;
                  clr_cnt <= '0;
                  state   <= CLEAR_LINE;
                end else begin
                  cur_col <= cur_col + 7'd1;
                end
              end
            endcase
          end
        end

        default: begin
          // Unreachable encoding: recover through a full screen clear.
          state    <= CLEAR_SCREEN;
          clr_row  <= 6'd0;
          clr_col  <= 7'd0;
          clr_cnt  <= '0;
          oWriteEn <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_text_console.sv
module tb_text_console;

  localparam int COLS = 80;
  localparam int ROWS = 30;
  localparam logic [31:0] BLANK = 32'h00000020;

  logic        iClk = 1'b0;
  logic        iRst;
  logic        iValid;
  logic        oReady;
  logic [7:0]  iChar;
  logic [23:0] iColor;
  logic        oWriteEn;
  logic [31:0] oWAddr;
  logic [31:0] oWData;
  logic [5:0]  oCursorRow;
  logic [6:0]  oCursorCol;
  logic        oBusy;

  int tests    = 0;
  int failed   = 0;
  int wr_count = 0;

  // Scoreboard entries: {addr, data}
  logic [63:0] sb[$];

  // Reference cursor
  int mrow = 0;
  int mcol = 0;

  text_console dut (
    .iClk       (iClk),
    .iRst       (iRst),
    .iValid     (iValid),
    .oReady     (oReady),
    .iChar      (iChar),
    .iColor     (iColor),
    .oWriteEn   (oWriteEn),
    .oWAddr     (oWAddr),
    .oWData     (oWData),
    .oCursorRow (oCursorRow),
    .oCursorCol (oCursorCol),
    .oBusy      (oBusy)
  );

  always #5 iClk = ~iClk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Every write the DUT issues must be the next expected one.
  always @(negedge iClk) begin
    if (oWriteEn === 1'b1) begin
      logic [63:0] exp;
      wr_count++;
      tests++;
      if (sb.size() == 0) begin
        assert (1'b0) else begin
          failed++;
          $error("FAIL unexpected_write: observed addr %h data %h, required no write", oWAddr, oWData);
        end
      end else begin
        exp = sb.pop_front();
        assert ({oWAddr, oWData} === exp) else begin
          failed++;
          $error("FAIL write_%0d: observed addr %h data %h, required addr %h data %h",
                 wr_count, oWAddr, oWData, exp[63:32], exp[31:0]);
        end
      end
    end
  end

  function automatic logic [31:0] addr_of(input int r, input int c);
    logic [5:0] rr;
    logic [6:0] cc;
    rr = 6'(r);
    cc = 7'(c);
    return {19'd0, rr, cc};
  endfunction

  task automatic push_line(input int r);
    for (int c = 0; c < COLS; c++) sb.push_back({addr_of(r, c), BLANK});
  endtask

  task automatic push_screen();
    for (int r = 0; r < ROWS; r++) push_line(r);
  endtask

  task automatic step();
    @(posedge iClk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h, required %h", tag, obs, exp);
    end
  endtask

  // Waits for oReady, returns with the count of cycles spent, then lets the
  // monitor drain the last write before checking the scoreboard is empty.
  task automatic wait_ready(input string tag, input int lat);
    int n;
    n = 0;
    while (oReady !== 1'b1 && n < lat + 100) begin
      step();
      n++;
    end
    chk({tag, "_latency"}, 32'(n), 32'(lat));
    @(negedge iClk);
    #1;
    chk({tag, "_drained"}, 32'(sb.size()), 32'd0);
  endtask

  // Presents one character; returns at cycle N+1 (#1 after the accept edge).
  task automatic send(input logic [7:0] c, input logic [23:0] col);
    int n;
    n = 0;
    while (oReady !== 1'b1 && n < 5000) begin
      step();
      n++;
    end
    if (oReady !== 1'b1) chk("send_ready", {31'd0, oReady}, 32'd1);
    iValid = 1'b1;
    iChar  = c;
    iColor = col;
    step();
    iValid = 1'b0;
    iChar  = 8'h00;
    iColor = 24'h0;
  endtask

  // Reference behaviour: push the expected writes, update the cursor,
  // send, then verify N+1 strobe, ready latency and cursor.
  task automatic do_char(input string tag, input logic [7:0] c, input logic [23:0] col);
    int lat;
    logic we1;
    lat = 0;
    we1 = 1'b0;
    case (c)
      8'h0A: begin
        mrow = (mrow == ROWS - 1) ? 0 : mrow + 1;
        mcol = 0;
        push_line(mrow);
        lat = COLS;
        we1 = 1'b1;
      end
      8'h0D: mcol = 0;
      8'h08: begin
        if (mcol > 0) begin
          mcol--;
          sb.push_back({addr_of(mrow, mcol), BLANK});
          we1 = 1'b1;
        end
      end
      8'h0C: begin
        mrow = 0;
        mcol = 0;
        push_screen();
        lat = ROWS * COLS;
        we1 = 1'b1;
      end
      default: begin
        sb.push_back({addr_of(mrow, mcol), {col, c}});
        we1 = 1'b1;
        if (mcol == COLS - 1) begin
          mcol = 0;
          mrow = (mrow == ROWS - 1) ? 0 : mrow + 1;
          push_line(mrow);
          lat = COLS + 1;
        end else begin
          mcol++;
        end
      end
    endcase
    send(c, col);
    chk({tag, "_we_n1"}, {31'd0, oWriteEn}, {31'd0, we1});
    wait_ready(tag, lat);
    chk({tag, "_row"}, {26'd0, oCursorRow}, 32'(mrow));
    chk({tag, "_col"}, {25'd0, oCursorCol}, 32'(mcol));
  endtask

  initial begin
    int base;
    int n;
    iRst   = 1'b1;
    iValid = 1'b0;
    iChar  = 8'h00;
    iColor = 24'h0;

    // Reset state
    step();
    step();
    chk("rst_we",    {31'd0, oWriteEn}, 32'd0);
    chk("rst_addr",  oWAddr, 32'd0);
    chk("rst_data",  oWData, 32'd0);
    chk("rst_row",   {26'd0, oCursorRow}, 32'd0);
    chk("rst_col",   {25'd0, oCursorCol}, 32'd0);
    chk("rst_ready", {31'd0, oReady}, 32'd0);
    chk("rst_busy",  {31'd0, oBusy}, 32'd1);

    // Power-up clear: 2400 contiguous blanks, ready the cycle after the last
    push_screen();
    base = wr_count;
    iRst = 1'b0;
    wait_ready("init", ROWS * COLS + 1);
    chk("init_count", 32'(wr_count - base), 32'd2400);
    chk("init_row",   {26'd0, oCursorRow}, 32'd0);
    chk("init_col",   {25'd0, oCursorCol}, 32'd0);
    chk("init_busy",  {31'd0, oBusy}, 32'd0);

    // Printable 'A' in red at (0,0)
    do_char("char_A", 8'h41, 24'hFF0000);
    chk("char_A_col_lit", {25'd0, oCursorCol}, 32'd1);
    chk("char_A_ready",   {31'd0, oReady}, 32'd1);

    // Carriage return: no write, column back to 0
    do_char("cr", 8'h0D, 24'h123456);

    // Move to (3,10)
    for (int i = 0; i < 3; i++) do_char("lf_pre", 8'h0A, 24'h0);
    for (int i = 0; i < 10; i++) do_char("fill3", 8'h61 + 8'(i), 24'h00FF00);
    chk("at_3_10_col", {25'd0, oCursorCol}, 32'd10);

    // Newline from (3,10): row 4 cleared (0x200..0x24F), 80 busy cycles
    base = wr_count;
    do_char("lf_3_10", 8'h0A, 24'h0);
    chk("lf_count",   32'(wr_count - base), 32'd80);
    chk("lf_row_lit", {26'd0, oCursorRow}, 32'd4);

    // Backspace at column 0 and at column 4 of row 5
    do_char("lf_to5", 8'h0A, 24'h0);
    do_char("bs_col0", 8'h08, 24'hABCDEF);
    chk("bs_col0_row", {26'd0, oCursorRow}, 32'd5);
    for (int i = 0; i < 4; i++) do_char("fill5", 8'h30 + 8'(i), 24'h0000FF);
    do_char("bs_col4", 8'h08, 24'h0);
    chk("bs_col4_col_lit", {25'd0, oCursorCol}, 32'd3);

    // Reach (29,79) then print 'Z': char at 0xECF, row 0 cleared, cursor (0,0)
    do_char("cr5", 8'h0D, 24'h0);
    for (int i = 0; i < 24; i++) do_char("lf_down", 8'h0A, 24'h0);
    for (int i = 0; i < COLS - 1; i++) do_char("fill29", 8'h21 + 8'(i % 90), 24'h808080);
    chk("at_29_79_row", {26'd0, oCursorRow}, 32'd29);
    chk("at_29_79_col", {25'd0, oCursorCol}, 32'd79);
    do_char("wrap_Z", 8'h5A, 24'h00FFFF);
    chk("wrap_row_lit", {26'd0, oCursorRow}, 32'd0);
    chk("wrap_col_lit", {25'd0, oCursorCol}, 32'd0);

    // Form feed interrupted by reset at cell 1000
    push_screen();
    mrow = 0;
    mcol = 0;
    base = wr_count;
    send(8'h0C, 24'h0);
    chk("ff_we_n1", {31'd0, oWriteEn}, 32'd1);
    n = 0;
    while (wr_count < base + 1000 && n < 5000) begin
      step();
      n++;
    end
    chk("ff_reached_1000", 32'(wr_count - base), 32'd1000);
    iRst = 1'b1;
    step();
    chk("ff_rst_we",    {31'd0, oWriteEn}, 32'd0);
    chk("ff_rst_addr",  oWAddr, 32'd0);
    chk("ff_rst_ready", {31'd0, oReady}, 32'd0);
    sb.delete();
    push_screen();
    base = wr_count;
    iRst = 1'b0;
    wait_ready("ff_restart", ROWS * COLS + 1);
    chk("ff_restart_count", 32'(wr_count - base), 32'd2400);
    chk("ff_restart_row",   {26'd0, oCursorRow}, 32'd0);
    chk("ff_restart_col",   {25'd0, oCursorCol}, 32'd0);

    // Uninterrupted form feed from a nonzero cursor
    do_char("post_B", 8'h42, 24'h0000FF);
    do_char("ff_full", 8'h0C, 24'h0);

    step();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
